// File: rtl/jogo_pkg.sv
// jogo_pkg: shared turn-FSM state codes, player constants and default turn timeout.
package jogo_pkg;
   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      ESPERA_MACRO   = 4'd2,
      REGISTRA_MACRO = 4'd3,
      ESPERA_MICRO   = 4'd4,
      REGISTRA_MICRO = 4'd5,
      VERIFICA       = 4'd6,
      LIMPA_MICRO    = 4'd7,
      TROCA          = 4'd8,
      FIM            = 4'd9,
      TIMEOUT_ST     = 4'd10
   } estado_t;
   localparam logic JOGADOR_X = 1'b0;
   localparam logic JOGADOR_O = 1'b1;
   localparam int TIMEOUT_CICLOS_PADRAO = 5000;
   function automatic logic outro_jogador(input logic j);
      return j == JOGADOR_X ? JOGADOR_O : JOGADOR_X;
   endfunction
endpackage

// File: rtl/contador_timeout.sv
// contador_timeout: per-selection cycle counter; fim flags the last allowed waiting cycle.
module contador_timeout
   import jogo_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int TW = $clog2(TIMEOUT_CICLOS)
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);
   logic [TW-1:0] cnt;
   always_ff @(posedge clock or negedge reset)
      if (!reset) cnt <= '0;
      else if (zera) cnt <= '0;
      else if (conta) cnt <= cnt + 1'b1;
   assign fim = conta && cnt == TW'(TIMEOUT_CICLOS - 1);
endmodule

// File: rtl/unidade_controle_jogada.sv
// unidade_controle_jogada: Moore FSM sequencing one ultimate tic-tac-toe turn.
// Optional per-selection turn timeout enabled by defining JOGADA_TIMEOUT_EN.
module unidade_controle_jogada
   import jogo_pkg::*;
`ifdef JOGADA_TIMEOUT_EN
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int TW = $clog2(TIMEOUT_CICLOS)
)
`endif
(
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       jogada_valida,
   input  logic       fim_jogo,
   output logic       zeraEdge,
   output logic       zeraR_macro,
   output logic       zeraR_micro,
   output logic       registraR_macro,
   output logic       registraR_micro,
   output logic       jogador,
   output logic       pronto,
   output logic       timeout,
   output logic [3:0] db_estado
);
   estado_t estado, proximo;
   logic jogador_prox, expirou;
`ifdef JOGADA_TIMEOUT_EN
   logic esperando;
   assign esperando = estado == ESPERA_MACRO || estado == ESPERA_MICRO;
   contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS), .TW(TW)) u_contador (
      .clock(clock),
      .reset(reset),
      .zera(!esperando),
      .conta(esperando),
      .fim(expirou)
   );
`else
   assign expirou = 1'b0;
`endif
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         estado  <= INICIAL;
         jogador <= JOGADOR_X;
      end else begin
         estado  <= proximo;
         jogador <= jogador_prox;
      end
   always_comb begin
      proximo         = INICIAL;
      jogador_prox    = jogador;
      zeraEdge        = 1'b0;
      zeraR_macro     = 1'b0;
      zeraR_micro     = 1'b0;
      registraR_macro = 1'b0;
      registraR_micro = 1'b0;
      pronto          = 1'b0;
      timeout         = 1'b0;
      case (estado)
         INICIAL: begin
            {zeraEdge, zeraR_macro, zeraR_micro} = 3'b111;
            proximo = iniciar ? PREPARA : INICIAL;
         end
         PREPARA: begin
            {zeraEdge, zeraR_macro, zeraR_micro} = 3'b111;
            jogador_prox = JOGADOR_X;
            proximo = ESPERA_MACRO;
         end
         // a press always beats a simultaneous expiry
         ESPERA_MACRO: proximo = jogada_feita ? REGISTRA_MACRO : expirou ? TIMEOUT_ST : ESPERA_MACRO;
         REGISTRA_MACRO: begin
            registraR_macro = 1'b1;
            proximo = ESPERA_MICRO;
         end
         ESPERA_MICRO: proximo = jogada_feita ? REGISTRA_MICRO : expirou ? TIMEOUT_ST : ESPERA_MICRO;
         REGISTRA_MICRO: begin
            registraR_micro = 1'b1;
            proximo = VERIFICA;
         end
         VERIFICA: proximo = jogada_valida ? TROCA : LIMPA_MICRO;
         LIMPA_MICRO: begin
            {zeraEdge, zeraR_micro} = 2'b11;
            proximo = ESPERA_MICRO;
         end
         TROCA: begin
            {zeraEdge, zeraR_macro, zeraR_micro} = 3'b111;
            jogador_prox = fim_jogo ? jogador : outro_jogador(jogador);
            proximo = fim_jogo ? FIM : ESPERA_MACRO;
         end
         FIM: begin
            pronto = 1'b1;
            proximo = iniciar ? PREPARA : FIM;
         end
`ifdef JOGADA_TIMEOUT_EN
         TIMEOUT_ST: begin
            timeout = 1'b1;
            {zeraEdge, zeraR_macro, zeraR_micro} = 3'b111;
            jogador_prox = outro_jogador(jogador);
            proximo = ESPERA_MACRO;
         end
`endif
         default: proximo = INICIAL;
      endcase
   end
   assign db_estado = estado;
endmodule

// File: doc/unidade_controle_jogada.md
Name: unidade_controle_jogada

Overview:
- Moore FSM that sequences one turn of the 9x9 ultimate tic-tac-toe game: macro-board selection, then micro-cell selection, then validation and player swap.
- Sits directly upstream of fluxo_dados and drives its edge-detector clear and its macro/micro register clear/enable strobes.
- Consumes the debounced one-cycle `jogada_feita` pulse and the validity/end-of-game flags returned by the datapath.

Parameters:
- TIMEOUT_CICLOS, 5000, cycles allowed per selection before the turn is forfeited (only used with TIMEOUT_EN).
- TW, $clog2(TIMEOUT_CICLOS), timeout counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start-game request, level, sampled each cycle.
- jogada_feita  in  1  one-cycle pulse: a button press was detected.
- jogada_valida  in  1  datapath: the registered macro/micro target is empty/allowed; meaningful in VERIFICA.
- fim_jogo  in  1  datapath: win or draw detected; meaningful in TROCA.
- zeraEdge  out  1  clear for the edge detector.
- zeraR_macro  out  1  clear for the macro register.
- zeraR_micro  out  1  clear for the micro register.
- registraR_macro  out  1  enable for the macro register.
- registraR_micro  out  1  enable for the micro register.
- jogador  out  1  current player: 0 = X, 1 = O.
- pronto  out  1  game over, held high in FIM.
- timeout  out  1  one-cycle pulse when a turn is forfeited.
- db_estado  out  4  state code, for debug displays.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = INICIAL, jogador = 0, counter = 0.
  - All outputs 0, except zeraEdge = zeraR_macro = zeraR_micro = 1, which are decoded from INICIAL.
- Outputs are Moore, decoded from the state register. Every transition takes effect on the next rising clock edge.
- States and db_estado codes:
  - INICIAL (0): clears asserted. iniciar=1 -> PREPARA; otherwise stay.
  - PREPARA (1): zeraEdge, zeraR_macro and zeraR_micro = 1; jogador <= 0. Unconditionally -> ESPERA_MACRO.
  - ESPERA_MACRO (2): jogada_feita=1 -> REGISTRA_MACRO.
  - REGISTRA_MACRO (3): registraR_macro = 1. -> ESPERA_MICRO.
  - ESPERA_MICRO (4): jogada_feita=1 -> REGISTRA_MICRO.
  - REGISTRA_MICRO (5): registraR_micro = 1. -> VERIFICA.
  - VERIFICA (6): no strobes; gives the datapath one cycle to compare.
    - jogada_valida=1 -> TROCA.
    - jogada_valida=0 -> LIMPA_MICRO.
  - LIMPA_MICRO (7): zeraR_micro = 1, zeraEdge = 1. -> ESPERA_MICRO. The macro choice is kept.
  - TROCA (8):
    - fim_jogo=1 -> FIM, jogador unchanged.
    - fim_jogo=0 -> jogador <= ~jogador; zeraR_macro, zeraR_micro and zeraEdge = 1; -> ESPERA_MACRO.
  - FIM (9): pronto = 1. iniciar=1 -> PREPARA; otherwise stay.
  - TIMEOUT_ST (10): only with TIMEOUT_EN. timeout = 1; clears as in TROCA; jogador toggles. -> ESPERA_MACRO.
  - Codes 11-15 are illegal -> INICIAL on the next edge.
- Latency: a press pulse in ESPERA_x produces registraR_x exactly 1 cycle later. This requires botoes to be held for at least 2 cycles after the pulse, which the debounced buttons satisfy.
- jogada_feita is ignored in every state other than ESPERA_MACRO and ESPERA_MICRO. A pulse arriving in REGISTRA_x, VERIFICA or LIMPA_MICRO is dropped.
- iniciar is ignored outside INICIAL and FIM. There is no mid-game restart except via reset.
- Reset asserted mid-turn returns to INICIAL immediately, regardless of the current state.

Optional Feature:
- Macro: JOGADA_TIMEOUT_EN.
- Defined:
  - A TW-bit counter is cleared on every entry into ESPERA_MACRO or ESPERA_MICRO and increments on each cycle spent there.
  - If the counter reaches TIMEOUT_CICLOS-1 with no jogada_feita, the next state is TIMEOUT_ST.
  - If jogada_feita and expiry occur in the same cycle, jogada_feita wins.
  - The counter holds 0 in all other states.
- Undefined:
  - No counter is built; timeout is tied to 0 and TIMEOUT_ST is unreachable.
  - Code 10 is treated as illegal and goes to INICIAL.

Decomposition:
- Package jogo_pkg holds:
  - the 4-bit state enum with the codes listed above;
  - the player constants JOGADOR_X=0 and JOGADOR_O=1;
  - the default TIMEOUT_CICLOS.
- One sub-module, contador_timeout, with ports clock, reset, zera, conta, fim. It is instantiated only under JOGADA_TIMEOUT_EN.

Test Plan:
- Reset, then iniciar=1 for 1 cycle:
  - db_estado goes 0 -> 1 -> 2;
  - the three clears are high in PREPARA; jogador=0.
- Valid turn: pulse in state 2, pulse in state 4, jogada_valida=1, fim_jogo=0:
  - registraR_macro is high exactly 1 cycle after the first pulse;
  - registraR_micro is high exactly 1 cycle after the second pulse;
  - the sequence passes through 6 and 8, then returns to 2 with jogador=1.
- Invalid micro: jogada_valida=0 in VERIFICA:
  - the sequence is 6 -> 7 -> 4;
  - zeraR_micro=1 for one cycle, registraR_macro not reasserted, jogador unchanged.
- End of game: fim_jogo=1 in TROCA:
  - state 9, pronto=1 held, jogador unchanged;
  - iniciar=1 -> state 1 on the next edge.
- Stray pulse: jogada_feita in state 3 or 6 has no effect on the state sequence.
- Reset low while in state 5: state=0 immediately, without waiting for a clock edge.
- With JOGADA_TIMEOUT_EN and TIMEOUT_CICLOS=8, idle in state 2:
  - after 8 cycles the state goes to 10 with timeout=1 for 1 cycle, then to 2 with jogador toggled;
  - a press coinciding with expiry leads to 3 instead.
